// File: rtl/typedef_collection.sv
// Shared types for the chipset: data words, memory access kinds,
// arbiter state/owner encodings and small arbitration helpers.
`ifndef REGSIZE
`define REGSIZE 32
`endif

package typedef_collection;

    typedef logic [`REGSIZE-1:0] DEFAULT_TYPE;

    typedef enum logic {
        MEMORY_READ  = 1'b0,
        MEMORY_WRITE = 1'b1
    } MEMORY_FLAG_TYPE;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_A = 2'd1,
        ARB_OWN_B = 2'd2
    } ARB_STATE_TYPE;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_A    = 2'd1,
        ARB_B    = 2'd2
    } ARB_OWNER_TYPE;

    // Choose a new owner from the requesting ports; ties go to the rr pointer.
    function automatic ARB_STATE_TYPE arb_pick(
        input logic a_req,
        input logic b_req,
        input logic prefer_a
    );
        ARB_STATE_TYPE pick;
        pick = ARB_IDLE;
        if (a_req && b_req) begin
            pick = prefer_a ? ARB_OWN_A : ARB_OWN_B;
        end else if (a_req) begin
            pick = ARB_OWN_A;
        end else if (b_req) begin
            pick = ARB_OWN_B;
        end
        return pick;
    endfunction

    function automatic ARB_OWNER_TYPE arb_owner_of(input ARB_STATE_TYPE s);
        ARB_OWNER_TYPE o;
        o = ARB_NONE;
        if (s == ARB_OWN_A) begin
            o = ARB_A;
        end else if (s == ARB_OWN_B) begin
            o = ARB_B;
        end
        return o;
    endfunction

endpackage

// File: rtl/arbiter_hold_counter.sv
// Counts consecutive owned cycles of the current bus owner and flags
// when the owner has used its last cycle under contention.
module arbiter_hold_counter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              inc,
    output logic [HOLD_W-1:0] count,
    output logic              at_limit
);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + HOLD_W'(1);
        end
    end

    // Saturated counts still count as "at limit" so a late contender switches next edge.
    assign at_limit = (count >= HOLD_W'(MAX_HOLD - 1));

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter in front of memory_unit: round-robin on contention,
// bounded hold under contention, owner's access muxed onto the mem_* bus.
module memory_bus_arbiter
    import typedef_collection::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            a_req,
    input  MEMORY_FLAG_TYPE a_ctrl_bus,
    input  DEFAULT_TYPE     a_addr_bus,
    input  DEFAULT_TYPE     a_write_bus,
    output logic            a_gnt,
    output DEFAULT_TYPE     a_read_bus,
    input  logic            b_req,
    input  MEMORY_FLAG_TYPE b_ctrl_bus,
    input  DEFAULT_TYPE     b_addr_bus,
    input  DEFAULT_TYPE     b_write_bus,
    output logic            b_gnt,
    output DEFAULT_TYPE     b_read_bus,
    output MEMORY_FLAG_TYPE mem_ctrl_bus,
    output DEFAULT_TYPE     mem_addr_bus,
    output DEFAULT_TYPE     mem_write_bus,
    input  DEFAULT_TYPE     mem_read_bus,
    output ARB_OWNER_TYPE   arb_owner
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    ARB_STATE_TYPE     state;
    ARB_STATE_TYPE     state_next;
    logic              rr_prefer_a;
    logic [HOLD_W-1:0] hold_count;
    logic              hold_at_limit;
    logic              hold_clear;
    logic              hold_inc;
    logic              hold_stay;
    logic              a_active;
    logic              b_active;

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                state_next = arb_pick(a_req, b_req, rr_prefer_a);
            end
            ARB_OWN_A: begin
                if (!a_req) begin
                    state_next = b_req ? ARB_OWN_B : ARB_IDLE;
                end else if (b_req && hold_at_limit) begin
                    state_next = ARB_OWN_B;
                end
            end
            ARB_OWN_B: begin
                if (!b_req) begin
                    state_next = a_req ? ARB_OWN_A : ARB_IDLE;
                end else if (a_req && hold_at_limit) begin
                    state_next = ARB_OWN_A;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Count only while the same master keeps the bus; any change or idle restarts it.
    assign hold_stay  = (state != ARB_IDLE) && (state_next == state);
    assign hold_clear = !hold_stay;
    assign hold_inc   = hold_stay && (hold_count != HOLD_W'(MAX_HOLD));

    arbiter_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_hold (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .clear    (hold_clear),
        .inc      (hold_inc),
        .count    (hold_count),
        .at_limit (hold_at_limit)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= ARB_IDLE;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            arb_owner   <= ARB_NONE;
            rr_prefer_a <= 1'b1;
        end else begin
            state     <= state_next;
            a_gnt     <= (state_next == ARB_OWN_A);
            b_gnt     <= (state_next == ARB_OWN_B);
            arb_owner <= arb_owner_of(state_next);
            if (state_next != state && state_next != ARB_IDLE) begin
                rr_prefer_a <= (state_next == ARB_OWN_B);
            end
        end
    end

    // An owner that has dropped req drives nothing, so a stale WRITE never reaches memory.
    assign a_active = a_gnt && a_req;
    assign b_active = b_gnt && b_req;

    always_comb begin
        mem_ctrl_bus  = MEMORY_READ;
        mem_addr_bus  = '0;
        mem_write_bus = '0;
        unique case (1'b1)
            a_active: begin
                mem_ctrl_bus  = a_ctrl_bus;
                mem_addr_bus  = a_addr_bus;
                mem_write_bus = a_write_bus;
            end
            b_active: begin
                mem_ctrl_bus  = b_ctrl_bus;
                mem_addr_bus  = b_addr_bus;
                mem_write_bus = b_write_bus;
            end
            default: begin
            end
        endcase
    end

    assign a_read_bus = a_gnt ? mem_read_bus : '0;
    assign b_read_bus = b_gnt ? mem_read_bus : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with a behavioural ownership model,
// a 16-word memory stub and per-cycle output comparison.
module tb_memory_bus_arbiter;
    import typedef_collection::*;

    localparam int MAX_HOLD = 8;

    logic            CLOCK;
    logic            RESET;
    logic            a_req;
    MEMORY_FLAG_TYPE a_ctrl_bus;
    DEFAULT_TYPE     a_addr_bus;
    DEFAULT_TYPE     a_write_bus;
    logic            a_gnt;
    DEFAULT_TYPE     a_read_bus;
    logic            b_req;
    MEMORY_FLAG_TYPE b_ctrl_bus;
    DEFAULT_TYPE     b_addr_bus;
    DEFAULT_TYPE     b_write_bus;
    logic            b_gnt;
    DEFAULT_TYPE     b_read_bus;
    MEMORY_FLAG_TYPE mem_ctrl_bus;
    DEFAULT_TYPE     mem_addr_bus;
    DEFAULT_TYPE     mem_write_bus;
    DEFAULT_TYPE     mem_read_bus;
    ARB_OWNER_TYPE   arb_owner;

    int checks = 0;
    int errors = 0;
    bit checking = 0;
    bit mem_init = 1;

    DEFAULT_TYPE mem [16];

    memory_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .a_req         (a_req),
        .a_ctrl_bus    (a_ctrl_bus),
        .a_addr_bus    (a_addr_bus),
        .a_write_bus   (a_write_bus),
        .a_gnt         (a_gnt),
        .a_read_bus    (a_read_bus),
        .b_req         (b_req),
        .b_ctrl_bus    (b_ctrl_bus),
        .b_addr_bus    (b_addr_bus),
        .b_write_bus   (b_write_bus),
        .b_gnt         (b_gnt),
        .b_read_bus    (b_read_bus),
        .mem_ctrl_bus  (mem_ctrl_bus),
        .mem_addr_bus  (mem_addr_bus),
        .mem_write_bus (mem_write_bus),
        .mem_read_bus  (mem_read_bus),
        .arb_owner     (arb_owner)
    );

    initial begin
        CLOCK = 0;
        forever #5 CLOCK = ~CLOCK;
    end

    // memory_unit stand-in: combinational read, write committed at the clock edge
    always @(posedge CLOCK) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + 32'(i * 3);
        end else if (mem_ctrl_bus == MEMORY_WRITE) begin
            mem[mem_addr_bus[3:0]] <= mem_write_bus;
        end
    end
    assign mem_read_bus = mem[mem_addr_bus[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Ownership model: 0 none, 1 A, 2 B; held = cycles owned including the current one
    int m_owner = 0;
    int m_held = 0;
    int m_pref = 1;

    always @(posedge CLOCK or posedge RESET) begin : model
        int nx_o;
        int nx_h;
        int nx_p;
        bit own_r;
        bit oth_r;
        if (RESET) begin
            m_owner <= 0;
            m_held  <= 0;
            m_pref  <= 1;
        end else begin
            own_r = (m_owner == 1 && a_req) || (m_owner == 2 && b_req);
            oth_r = (m_owner == 1 && b_req) || (m_owner == 2 && a_req);
            nx_o = m_owner;
            nx_h = m_held;
            nx_p = m_pref;
            if (own_r && (!oth_r || m_held < MAX_HOLD)) begin
                nx_h = (m_held < MAX_HOLD) ? m_held + 1 : m_held;
            end else begin
                if (a_req && b_req) nx_o = m_pref;
                else if (a_req) nx_o = 1;
                else if (b_req) nx_o = 2;
                else nx_o = 0;
                nx_h = (nx_o != 0) ? 1 : 0;
                if (nx_o != 0) nx_p = 3 - nx_o;
            end
            m_owner <= nx_o;
            m_held  <= nx_h;
            m_pref  <= nx_p;
        end
    end

    always @(negedge CLOCK) begin : compare
        bit          ow_req;
        bit          is_wr;
        DEFAULT_TYPE e_addr;
        DEFAULT_TYPE e_wdata;
        DEFAULT_TYPE e_rd;
        if (checking) begin
            ow_req  = (m_owner == 1 && a_req) || (m_owner == 2 && b_req);
            e_addr  = !ow_req ? '0 : (m_owner == 1) ? a_addr_bus : b_addr_bus;
            e_wdata = !ow_req ? '0 : (m_owner == 1) ? a_write_bus : b_write_bus;
            is_wr   = ow_req && ((m_owner == 1) ? (a_ctrl_bus == MEMORY_WRITE)
                                                : (b_ctrl_bus == MEMORY_WRITE));
            e_rd    = mem[e_addr[3:0]];
            chk("a_gnt", 32'(a_gnt), 32'(m_owner == 1));
            chk("b_gnt", 32'(b_gnt), 32'(m_owner == 2));
            chk("arb_owner", 32'(arb_owner), 32'(m_owner));
            chk("mem_ctrl", 32'(mem_ctrl_bus), 32'(is_wr));
            chk("mem_addr", mem_addr_bus, e_addr);
            chk("mem_wdata", mem_write_bus, e_wdata);
            chk("a_read", a_read_bus, (m_owner == 1) ? e_rd : '0);
            chk("b_read", b_read_bus, (m_owner == 2) ? e_rd : '0);
            chk("gnt_mutex", 32'(a_gnt && b_gnt), 32'(0));
            if (!a_gnt) chk("a_read_idle", a_read_bus, 32'(0));
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic at_neg();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic reset_pulse();
        RESET = 1;
        tick();
        RESET = 0;
    endtask

    initial begin
        RESET = 1;
        a_req = 0; a_ctrl_bus = MEMORY_READ; a_addr_bus = '0; a_write_bus = '0;
        b_req = 0; b_ctrl_bus = MEMORY_READ; b_addr_bus = '0; b_write_bus = '0;

        // reset state
        @(posedge CLOCK);
        at_neg();
        chk("rst_a_gnt", 32'(a_gnt), 32'(0));
        chk("rst_b_gnt", 32'(b_gnt), 32'(0));
        chk("rst_owner", 32'(arb_owner), 32'(ARB_NONE));
        chk("rst_ctrl", 32'(mem_ctrl_bus), 32'(MEMORY_READ));
        chk("rst_addr", mem_addr_bus, 32'(0));
        tick();
        mem_init = 0;
        RESET = 0;
        checking = 1;

        // 1: lone A write
        a_req = 1; a_ctrl_bus = MEMORY_WRITE; a_addr_bus = 5; a_write_bus = 32'h2A;
        at_neg();
        chk("t1_no_same_cycle", 32'(a_gnt), 32'(0));
        tick();
        at_neg();
        chk("t1_a_gnt", 32'(a_gnt), 32'(1));
        chk("t1_b_gnt", 32'(b_gnt), 32'(0));
        chk("t1_ctrl", 32'(mem_ctrl_bus), 32'(MEMORY_WRITE));
        chk("t1_addr", mem_addr_bus, 32'(5));
        tick();
        a_req = 0;
        at_neg();
        chk("t1_mem5", mem[5], 32'h2A);
        chk("t1_drop_ctrl", 32'(mem_ctrl_bus), 32'(MEMORY_READ));
        tick();
        a_ctrl_bus = MEMORY_READ;

        // 5: owner drops req while still driving WRITE
        b_req = 1; b_ctrl_bus = MEMORY_READ; b_addr_bus = 9;
        tick();
        at_neg();
        chk("t5_b_gnt", 32'(b_gnt), 32'(1));
        chk("t5_b_read", b_read_bus, 32'h11B);
        tick();
        b_req = 0; b_ctrl_bus = MEMORY_WRITE; b_write_bus = 32'h77;
        at_neg();
        chk("t5_last_gnt", 32'(b_gnt), 32'(1));
        chk("t5_ctrl_read", 32'(mem_ctrl_bus), 32'(MEMORY_READ));
        tick();
        at_neg();
        chk("t5_mem9", mem[9], 32'h11B);
        b_ctrl_bus = MEMORY_READ;
        tick();

        // 2: simultaneous requests after reset, then hand-over with no gap
        reset_pulse();
        a_req = 1; a_addr_bus = 1; b_req = 1; b_addr_bus = 2;
        tick();
        at_neg();
        chk("t2_a_first", 32'(a_gnt), 32'(1));
        chk("t2_b_wait", 32'(b_gnt), 32'(0));
        a_req = 0;
        tick();
        at_neg();
        chk("t2_b_next", 32'(b_gnt), 32'(1));
        chk("t2_a_off", 32'(a_gnt), 32'(0));
        b_req = 0;
        tick();

        // 3: continuous contention alternates every MAX_HOLD cycles
        reset_pulse();
        a_req = 1; b_req = 1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            at_neg();
            chk("t3_a_gnt", 32'(a_gnt), 32'(((k - 1) / MAX_HOLD) % 2 == 0));
            chk("t3_b_gnt", 32'(b_gnt), 32'(((k - 1) / MAX_HOLD) % 2 == 1));
        end
        a_req = 0; b_req = 0;
        tick();

        // 4: B alone saturates its counter, then A contends
        reset_pulse();
        b_req = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            at_neg();
            chk("t4_b_alone", 32'(b_gnt), 32'(1));
        end
        a_req = 1;
        tick();
        at_neg();
        chk("t4_a_switch", 32'(a_gnt), 32'(1));
        chk("t4_b_off", 32'(b_gnt), 32'(0));
        for (int k = 2; k <= MAX_HOLD; k++) begin
            tick();
            at_neg();
            chk("t4_a_hold", 32'(a_gnt), 32'(1));
        end
        tick();
        at_neg();
        chk("t4_b_back", 32'(b_gnt), 32'(1));
        a_req = 0; b_req = 0;
        tick();
        tick();

        // 6: asynchronous reset in the middle of a grant
        reset_pulse();
        a_req = 1; a_ctrl_bus = MEMORY_WRITE; a_addr_bus = 3; a_write_bus = 32'hAA;
        tick();
        at_neg();
        chk("t6_a_gnt", 32'(a_gnt), 32'(1));
        #1 RESET = 1;
        #1;
        chk("t6_rst_a_gnt", 32'(a_gnt), 32'(0));
        chk("t6_rst_b_gnt", 32'(b_gnt), 32'(0));
        chk("t6_rst_ctrl", 32'(mem_ctrl_bus), 32'(MEMORY_READ));
        chk("t6_rst_addr", mem_addr_bus, 32'(0));
        chk("t6_rst_owner", 32'(arb_owner), 32'(ARB_NONE));
        #1 RESET = 0;
        a_ctrl_bus = MEMORY_READ;
        b_req = 1;
        tick();
        at_neg();
        chk("t6_a_pref", 32'(a_gnt), 32'(1));
        chk("t6_b_wait", 32'(b_gnt), 32'(0));
        a_req = 0; b_req = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
